// File: rtl/jam_cost_table.sv
// JAM worker/job cost table: row-major load, per-row minimum scan,
// then combinational (W, J) cost lookup with a published lower bound.
module jam_cost_table #(
    parameter int N  = 8,
    parameter int CW = 7,
    parameter int SW = 10
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   LD_VALID,
    output logic                   LD_READY,
    input  logic [CW-1:0]          LD_DATA,
    input  logic                   RELOAD,
    input  logic [$clog2(N)-1:0]   W,
    input  logic [$clog2(N)-1:0]   J,
    output logic [CW-1:0]          Cost,
    output logic                   Ready,
    output logic [SW-1:0]          LowerBound
);
    localparam int IW = $clog2(N);
    localparam int AW = 2 * IW;
    localparam logic [AW-1:0] LAST_IDX = AW'(N * N - 1);
    localparam logic [IW-1:0] LAST_ROW = IW'(N - 1);

    typedef enum logic [1:0] {LOAD, SCAN, SERVE} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   idx, idx_n;
    logic [IW-1:0]   row, row_n;
    logic [SW-1:0]   acc, acc_n;
    logic [SW-1:0]   lb, lb_n;
    logic            wr_en;
    logic [CW-1:0]   rmin;
    logic [CW-1:0]   mem [N*N];

    // Table storage carries no reset; contents are meaningless until loaded.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[idx] <= LD_DATA;
    end

    always_comb begin
        rmin = mem[{row, {IW{1'b0}}}];
        for (int c = 1; c < N; c++) begin
            if (mem[{row, IW'(c)}] < rmin) rmin = mem[{row, IW'(c)}];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= LOAD;
            idx   <= '0;
            row   <= '0;
            acc   <= '0;
            lb    <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            row   <= row_n;
            acc   <= acc_n;
            lb    <= lb_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        row_n   = row;
        acc_n   = acc;
        lb_n    = lb;
        wr_en   = 1'b0;
        unique case (state)
            LOAD: begin
                if (RELOAD) begin
                    idx_n = '0;
                    acc_n = '0;
                end else if (LD_VALID) begin
                    wr_en = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_n   = '0;
                        row_n   = '0;
                        acc_n   = '0;
                        state_n = SCAN;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            SCAN: begin
                if (RELOAD) begin
                    state_n = LOAD;
                    idx_n   = '0;
                    row_n   = '0;
                    acc_n   = '0;
                end else begin
                    acc_n = acc + SW'(rmin);
                    if (row == LAST_ROW) begin
                        lb_n    = acc + SW'(rmin);
                        row_n   = '0;
                        state_n = SERVE;
                    end else begin
                        row_n = row + 1'b1;
                    end
                end
            end
            SERVE: begin
                if (RELOAD) begin
                    state_n = LOAD;
                    idx_n   = '0;
                    row_n   = '0;
                    acc_n   = '0;
                    lb_n    = '0;
                end
            end
            default: state_n = LOAD;
        endcase
    end

    assign LD_READY   = (state == LOAD);
    assign Ready      = (state == SERVE);
    assign Cost       = Ready ? mem[{W, J}] : '0;
    assign LowerBound = lb;
endmodule

// File: tb/tb_jam_cost_table.sv
// Directed and randomized checks of jam_cost_table against a
// matrix/row-minimum reference model held in the bench.
module tb_jam_cost_table;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       LD_VALID = 1'b0;
    logic       LD_READY;
    logic [6:0] LD_DATA = '0;
    logic       RELOAD = 1'b0;
    logic [2:0] W = '0;
    logic [2:0] J = '0;
    logic [6:0] Cost;
    logic       Ready;
    logic [9:0] LowerBound;

    int n_assert = 0;
    int n_fail   = 0;
    int m [64];

    jam_cost_table dut (
        .CLK(CLK), .RST_N(RST_N), .LD_VALID(LD_VALID), .LD_READY(LD_READY),
        .LD_DATA(LD_DATA), .RELOAD(RELOAD), .W(W), .J(J), .Cost(Cost),
        .Ready(Ready), .LowerBound(LowerBound)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_lb();
        int s = 0;
        for (int r = 0; r < 8; r++) begin
            int mn = 1000;
            for (int c = 0; c < 8; c++)
                if (m[r*8+c] < mn) mn = m[r*8+c];
            s += mn;
        end
        return s;
    endfunction

    // Offer n beats of m[]; toggle inserts a stall cycle after every beat.
    task automatic load_beats(input int n, input bit toggle);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            if (k % 16 == 0) chk("ld_ready_load", LD_READY, 1);
            LD_VALID = 1'b1;
            LD_DATA  = 7'(m[k]);
            @(posedge CLK);
            if (toggle && k != n - 1) begin
                @(negedge CLK);
                LD_VALID = 1'b0;
                chk("ld_ready_stall", LD_READY, 1);
                @(posedge CLK);
            end
        end
        #1;
        LD_VALID = 1'b0;
    endtask

    // Called #1 after the last acceptance edge; counts edges until Ready.
    task automatic wait_ready(input bit push_scan);
        int cnt = 0;
        if (push_scan) begin
            LD_VALID = 1'b1;
            LD_DATA  = 7'h55;
            chk("ld_ready_scan", LD_READY, 0);
        end
        while (!Ready && cnt < 20) begin
            @(posedge CLK);
            #1;
            cnt++;
        end
        chk("ready_latency", cnt, 8);
        LD_VALID = 1'b0;
    endtask

    task automatic query(input int w, input int j);
        @(negedge CLK);
        W = 3'(w);
        J = 3'(j);
        #1;
        chk($sformatf("cost_w%0d_j%0d", w, j), Cost, m[w*8+j]);
    endtask

    task automatic sweep();
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++) query(w, j);
    endtask

    task automatic do_reload();
        @(negedge CLK);
        RELOAD = 1'b1;
        @(posedge CLK);
        #1;
        RELOAD = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_ld_ready", LD_READY, 1);
        chk("rst_ready", Ready, 0);
        chk("rst_cost", Cost, 0);
        chk("rst_lb", LowerBound, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int k = 0; k < 64; k++) m[k] = k;
        load_beats(64, 0);
        wait_ready(1);
        chk("ld_ready_serve", LD_READY, 0);
        query(3, 5);
        chk("lb_ramp", LowerBound, 224);
        chk("lb_ramp_ref", LowerBound, ref_lb());
        sweep();

        do_reload();
        chk("rl_ready", Ready, 0);
        chk("rl_cost", Cost, 0);
        chk("rl_lb", LowerBound, 0);
        chk("rl_ld_ready", LD_READY, 1);

        load_beats(64, 1);
        wait_ready(0);
        chk("lb_toggle", LowerBound, 224);
        for (int i = 0; i < 16; i++)
            query($urandom_range(0, 7), $urandom_range(0, 7));

        do_reload();
        for (int k = 0; k < 64; k++) m[k] = 127;
        load_beats(64, 0);
        wait_ready(0);
        chk("lb_max", LowerBound, 1016);
        query(7, 7);

        do_reload();
        for (int k = 0; k < 64; k++) m[k] = 1;
        m[2*8+6] = 0;
        load_beats(64, 0);
        wait_ready(0);
        chk("lb_one_zero", LowerBound, 7);
        query(2, 6);
        query(2, 5);

        do_reload();
        for (int k = 0; k < 64; k++) m[k] = int'($urandom_range(0, 127));
        load_beats(30, 0);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_ld_ready", LD_READY, 1);
        chk("mid_rst_ready", Ready, 0);
        chk("mid_rst_lb", LowerBound, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        @(negedge CLK);
        RELOAD   = 1'b1;
        LD_VALID = 1'b1;
        LD_DATA  = 7'h2a;
        @(posedge CLK);
        #1;
        RELOAD   = 1'b0;
        LD_VALID = 1'b0;

        for (int k = 0; k < 64; k++) m[k] = int'($urandom_range(0, 127));
        load_beats(64, 0);
        wait_ready(0);
        chk("lb_rand", LowerBound, ref_lb());
        sweep();

        do_reload();
        for (int k = 0; k < 64; k++) m[k] = int'($urandom_range(20, 127));
        load_beats(64, 1);
        wait_ready(1);
        chk("lb_rand2", LowerBound, ref_lb());
        for (int i = 0; i < 24; i++)
            query($urandom_range(0, 7), $urandom_range(0, 7));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Responder side of the JAM worker/job cost interface: holds the 8x8 worker-by-job cost matrix and answers (W, J) lookups with Cost.
- Matrix is loaded row-major over a valid/ready stream. After loading, the block scans each row for its minimum and publishes LowerBound, the sum of the 8 row minima, for search pruning.
- Sits between the host/loader and the JAM search engine.

Parameters:
- N, 8, matrix dimension (workers = jobs = N); index width is 3 bits at N=8.
- CW, 7, cost entry width in bits.
- SW, 10, LowerBound width in bits; must satisfy N*(2^CW-1) < 2^SW.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- LD_VALID  in  1  load beat valid.
- LD_READY  out  1  block accepts a load beat this cycle.
- LD_DATA  in  CW  cost entry; beat k is entry row k/N, column k%N.
- RELOAD  in  1  single-cycle request to discard the table and accept a new load.
- W  in  3  worker index of query.
- J  in  3  job index of query.
- Cost  out  CW  cost of worker W on job J.
- Ready  out  1  table loaded and scanned; Cost and LowerBound are valid.
- LowerBound  out  SW  sum over rows of the minimum entry in that row.

Behaviour:
- States: LOAD, SCAN, SERVE.
- Reset (RST_N low, asynchronous):
  - state=LOAD; load index=0; scan row=0; accumulator=0.
  - Outputs: LD_READY=1, Ready=0, Cost=0, LowerBound=0.
  - Table contents are don't-care after reset.
- LOAD:
  - LD_READY=1.
  - Each cycle with LD_VALID=1, write LD_DATA into entry[idx] and increment idx.
  - Cycles with LD_VALID=0 are stalls; no write, idx holds.
  - On the beat with idx=N*N-1: write it, move to SCAN next cycle, idx wraps to 0.
- SCAN:
  - LD_READY=0.
  - Runs exactly N cycles, one row per cycle, row r=0..N-1.
  - Each cycle: accumulator += min(entry[r][0..N-1]); the row minimum is computed combinationally over the N entries.
  - After row N-1: LowerBound <= final sum, move to SERVE.
  - Load-to-Ready latency: Ready=1 in the cycle after the last SCAN cycle, i.e. N cycles after the last load beat is accepted.
- SERVE:
  - Ready=1, LD_READY=0.
  - Cost = entry[W][J], combinational from the registered table: a W/J change is reflected in the same cycle.
  - LowerBound holds its value.
- Cost output: 0 whenever Ready=0, so the searcher never sees partial data.
- RELOAD:
  - Sampled in any state.
  - In SERVE: next state LOAD; Ready=0, LowerBound=0, idx=0, accumulator=0.
  - In LOAD or SCAN: restarts the load at idx=0 and clears the accumulator.
  - If RELOAD and LD_VALID are both high in LOAD: RELOAD wins and the beat is dropped, not written.
- Load beats offered in SCAN or SERVE: LD_VALID with LD_READY=0 is not accepted; the loader must hold the data.
- Arithmetic:
  - Accumulator and LowerBound are SW bits, unsigned, with no saturation; the parameter constraint guarantees no overflow. Max at defaults: 8*127 = 1016.
  - Minimum comparison is unsigned; on ties any equal entry is fine, since only the value is used.
- Reset mid-operation: asynchronous return to the reset values above, whether in LOAD, SCAN or SERVE; the partial load is discarded.

Test Plan:
- Load entry[r][c]=8*r+c with LD_VALID held high, then query W=3,J=5 → Cost=29; LowerBound=0+8+...+56=224; Ready rises exactly 8 cycles after the 64th beat.
- Same load with LD_VALID toggling every other cycle → table identical and LowerBound=224; LD_READY stays 1 through all 64 beats.
- All entries 127 → LowerBound=1016 (max, no overflow); query W=7,J=7 → Cost=127.
- In SERVE, pulse RELOAD → next cycle Ready=0, Cost=0, LowerBound=0, LD_READY=1. Load an all-1 matrix except entry[2][6]=0 → LowerBound=7, and W=2,J=6 gives Cost=0.
- Drop RST_N after 30 beats, release, then load a fresh 64-beat matrix → result matches that matrix only; a beat presented with RELOAD high in LOAD is not written.
- During SCAN, hold LD_VALID=1 → LD_READY=0 and no table write; sweep W/J in SERVE each cycle → Cost tracks entry[W][J] the same cycle.
